// File: rtl/tomasula_types.sv
// tomasula_types: instruction class encoding shared by dispatch, ROB and reservation stations.
package tomasula_types;
  typedef enum logic [2:0] {OP_NONE, OP_ALU, OP_LD, OP_ST, OP_BR} op_t;
endpackage

// File: rtl/iq_dispatch.sv
// iq_dispatch: 8-deep RV32I instruction queue; decodes the head and dispatches one instruction per cycle to ROB and RS.
module iq_dispatch
  import tomasula_types::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic [31:0]      instr_pc,
  output logic             iq_ready,
  input  logic             rob_full,
  input  logic [TAG_W-1:0] rob_curr_ptr,
  output logic             rob_load,
  output op_t              instr_type,
  output logic [4:0]       rd,
  output logic [4:0]       st_src,
  input  logic             alu_rs_full,
  input  logic             mem_rs_full,
  input  logic             br_rs_full,
  output logic             rs_load,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic             funct7b5,
  output logic [6:0]       opcode,
  output logic [31:0]      imm,
  output logic [31:0]      pc_out,
  output logic [TAG_W-1:0] rob_tag,
  input  logic             branch_mispredict,
  output logic             illegal_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          w_ne, w_enq, w_disp, w_drop, w_deq;
  logic [31:0]   w_instr, w_pc, w_imm;
  logic [6:0]    w_op;
  logic          w_u, w_i, w_alu, w_ld, w_st, w_br, w_legal, w_cls_full;
  op_t           w_type;
  assign w_ne    = r_count != '0;
  assign w_instr = r_mem[r_head][63:32];
  assign w_pc    = r_mem[r_head][31:0];
  assign w_op    = w_instr[6:0];
  assign w_u     = w_op == 7'b0110111 || w_op == 7'b0010111;
  assign w_alu   = w_op == 7'b0110011 || w_op == 7'b0010011 || w_u;
  assign w_ld    = w_op == 7'b0000011;
  assign w_st    = w_op == 7'b0100011;
  assign w_br    = w_op == 7'b1100011;
  assign w_i     = w_op == 7'b0010011 || w_ld;
  assign w_legal = w_alu || w_ld || w_st || w_br;
  assign w_type  = w_alu ? OP_ALU : w_ld ? OP_LD : w_st ? OP_ST : w_br ? OP_BR : OP_NONE;
  assign w_imm   = w_i  ? {{20{w_instr[31]}}, w_instr[31:20]} :
                   w_st ? {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]} :
                   w_br ? {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0} :
                   w_u  ? {w_instr[31:12], 12'b0} : '0;
  assign w_cls_full = w_alu ? alu_rs_full : (w_ld || w_st) ? mem_rs_full : w_br ? br_rs_full : 1'b1;
  assign iq_ready = r_count != CW'(DEPTH);
  assign w_enq  = instr_valid && iq_ready && !branch_mispredict;
  assign w_disp = w_ne && w_legal && !rob_full && !w_cls_full && !branch_mispredict;
  assign w_drop = w_ne && !w_legal && !branch_mispredict;
  assign w_deq  = w_disp || w_drop;
  // Every data output reads zero while the queue is empty, not the stale head slot.
  assign rob_load      = w_disp;
  assign rs_load       = w_disp;
  assign illegal_instr = w_drop;
  assign instr_type    = w_ne ? w_type : OP_NONE;
  assign rd            = (w_ne && (w_alu || w_ld)) ? w_instr[11:7] : '0;
  assign st_src        = (w_ne && w_st) ? w_instr[24:20] : '0;
  assign rs1           = w_ne ? w_instr[19:15] : '0;
  assign rs2           = w_ne ? w_instr[24:20] : '0;
  assign funct3        = w_ne ? w_instr[14:12] : '0;
  assign funct7b5      = w_ne && w_instr[30];
  assign opcode        = w_ne ? w_op : '0;
  assign imm           = w_ne ? w_imm : '0;
  assign pc_out        = w_ne ? w_pc : '0;
  assign rob_tag       = w_ne ? rob_curr_ptr : '0;
  always_ff @(posedge clk)
    if (w_enq) r_mem[r_tail] <= {instr, instr_pc};
  always_ff @(posedge clk) begin
    if (rst || branch_mispredict) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + AW'(1);
      if (w_deq) r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end
endmodule

// File: tb/tb_iq_dispatch.sv
// tb_iq_dispatch: table-driven vectors plus hand sequences for full-queue, flush and reset corners.
module tb_iq_dispatch;
  import tomasula_types::*;
  logic        clk = 0, rst = 1;
  logic        instr_valid = 0, rob_full = 0, alu_rs_full = 0, mem_rs_full = 0, br_rs_full = 0, branch_mispredict = 0;
  logic [31:0] instr = 0, instr_pc = 0;
  logic [2:0]  rob_curr_ptr = 0;
  logic        iq_ready, rob_load, rs_load, funct7b5, illegal_instr;
  op_t         instr_type;
  logic [4:0]  rd, st_src, rs1, rs2;
  logic [2:0]  funct3, rob_tag;
  logic [6:0]  opcode;
  logic [31:0] imm, pc_out;
  int checks = 0, failures = 0;

  iq_dispatch #(.DEPTH(8), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .iq_ready(iq_ready), .rob_full(rob_full), .rob_curr_ptr(rob_curr_ptr), .rob_load(rob_load),
    .instr_type(instr_type), .rd(rd), .st_src(st_src), .alu_rs_full(alu_rs_full),
    .mem_rs_full(mem_rs_full), .br_rs_full(br_rs_full), .rs_load(rs_load), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7b5(funct7b5), .opcode(opcode), .imm(imm), .pc_out(pc_out),
    .rob_tag(rob_tag), .branch_mispredict(branch_mispredict), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [31:0] ins; logic [2:0] full; logic [2:0] ptr;
    logic e_rdy, e_load, e_ill; op_t e_type;
    logic [4:0] e_rd, e_st, e_rs1; logic [31:0] e_imm;
  } vec_t;

  function automatic vec_t row(logic v, logic [31:0] ins, logic [2:0] full, logic [2:0] ptr,
                               logic rdy, logic ld, logic ill, op_t t,
                               logic [4:0] rde, logic [4:0] ste, logic [4:0] rs1e, logic [31:0] imme);
    vec_t r;
    r.v = v; r.ins = ins; r.full = full; r.ptr = ptr;
    r.e_rdy = rdy; r.e_load = ld; r.e_ill = ill; r.e_type = t;
    r.e_rd = rde; r.e_st = ste; r.e_rs1 = rs1e; r.e_imm = imme;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] addi(int r, int k);
    return (32'(k) << 20) | (32'(r) << 7) | 32'h13;
  endfunction

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = row(0, 0,            3'b000, 0, 1, 0, 0, OP_NONE, 0, 0, 0, 0);
    vecs[1]  = row(1, 32'h00700293, 3'b000, 0, 1, 0, 0, OP_NONE, 0, 0, 0, 0);
    vecs[2]  = row(0, 0,            3'b000, 3, 1, 1, 0, OP_ALU,  5, 0, 0, 7);
    vecs[3]  = row(0, 0,            3'b000, 3, 1, 0, 0, OP_NONE, 0, 0, 0, 0);
    vecs[4]  = row(1, 32'h00612423, 3'b000, 3, 1, 0, 0, OP_NONE, 0, 0, 0, 0);
    vecs[5]  = row(0, 0,            3'b010, 4, 1, 0, 0, OP_ST,   0, 6, 2, 8);
    vecs[6]  = row(0, 0,            3'b010, 4, 1, 0, 0, OP_ST,   0, 6, 2, 8);
    vecs[7]  = row(0, 0,            3'b010, 4, 1, 0, 0, OP_ST,   0, 6, 2, 8);
    vecs[8]  = row(0, 0,            3'b000, 4, 1, 1, 0, OP_ST,   0, 6, 2, 8);
    vecs[9]  = row(1, 32'hFE208EE3, 3'b001, 5, 1, 0, 0, OP_NONE, 0, 0, 0, 0);
    vecs[10] = row(0, 0,            3'b001, 5, 1, 0, 0, OP_BR,   0, 0, 1, 32'hFFFFFFFC);
    vecs[11] = row(0, 0,            3'b110, 5, 1, 1, 0, OP_BR,   0, 0, 1, 32'hFFFFFFFC);
    vecs[12] = row(0, 0,            3'b000, 5, 1, 0, 0, OP_NONE, 0, 0, 0, 0);
    vecs[13] = row(1, 32'h00700293, 3'b000, 6, 1, 0, 0, OP_NONE, 0, 0, 0, 0);
    vecs[14] = row(1, 32'h0000007F, 3'b000, 6, 1, 1, 0, OP_ALU,  5, 0, 0, 7);
    vecs[15] = row(1, 32'h00100313, 3'b000, 7, 1, 0, 1, OP_NONE, 0, 0, 0, 0);
    vecs[16] = row(0, 0,            3'b000, 7, 1, 1, 0, OP_ALU,  6, 0, 0, 1);
    vecs[17] = row(0, 0,            3'b000, 7, 1, 0, 0, OP_NONE, 0, 0, 0, 0);
    next; next;
    rst = 0;
    for (int i = 0; i < 18; i++) begin
      instr_valid = vecs[i].v; instr = vecs[i].ins; instr_pc = 32'h1000 + 32'(i) * 4;
      {alu_rs_full, mem_rs_full, br_rs_full} = vecs[i].full;
      rob_curr_ptr = vecs[i].ptr;
      #1;
      chk("iq_ready", i, 32'(iq_ready), 32'(vecs[i].e_rdy));
      chk("rob_load", i, 32'(rob_load), 32'(vecs[i].e_load));
      chk("rs_load", i, 32'(rs_load), 32'(vecs[i].e_load));
      chk("illegal", i, 32'(illegal_instr), 32'(vecs[i].e_ill));
      chk("type", i, 32'(instr_type), 32'(vecs[i].e_type));
      chk("rd", i, 32'(rd), 32'(vecs[i].e_rd));
      chk("st_src", i, 32'(st_src), 32'(vecs[i].e_st));
      chk("rs1", i, 32'(rs1), 32'(vecs[i].e_rs1));
      chk("imm", i, imm, vecs[i].e_imm);
      if (vecs[i].e_load) chk("rob_tag", i, 32'(rob_tag), 32'(vecs[i].ptr));
      if (i == 10) begin
        chk("rs2", i, 32'(rs2), 2);
        chk("funct3", i, 32'(funct3), 0);
        chk("opcode", i, 32'(opcode), 32'h63);
        chk("funct7b5", i, 32'(funct7b5), 1);
        chk("pc_out", i, pc_out, 32'h1000 + 9 * 4);
      end
      next;
    end
    {alu_rs_full, mem_rs_full, br_rs_full} = 3'b000;
    // Fill with ROB blocked: 8 accepted, 9th held by fetch until a slot frees.
    rob_full = 1; rob_curr_ptr = 2;
    for (int k = 1; k <= 8; k++) begin
      instr_valid = 1; instr = addi(k, k); instr_pc = 32'h2000 + 32'(k) * 4;
      #1;
      chk("fill_rdy", k, 32'(iq_ready), 1);
      chk("fill_noload", k, 32'(rob_load), 0);
      next;
    end
    instr = addi(9, 9); instr_pc = 32'h2000 + 9 * 4;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("full_rdy", k, 32'(iq_ready), 0);
      chk("full_noload", k, 32'(rob_load), 0);
      next;
    end
    rob_full = 0;
    #1;
    chk("drain_rdy_full", 1, 32'(iq_ready), 0);
    chk("drain_load", 1, 32'(rob_load), 1);
    chk("drain_rd", 1, 32'(rd), 1);
    next;
    chk("drain_rdy_back", 2, 32'(iq_ready), 1);
    for (int k = 2; k <= 9; k++) begin
      if (k == 3) instr_valid = 0;
      #1;
      chk("drain_load", k, 32'(rob_load), 1);
      chk("drain_rd", k, 32'(rd), 32'(k));
      chk("drain_imm", k, imm, 32'(k));
      chk("drain_pc", k, pc_out, 32'h2000 + 32'(k) * 4);
      chk("drain_tag", k, 32'(rob_tag), 2);
      next;
    end
    chk("drain_empty", 0, 32'(rob_load), 0);
    chk("drain_empty_rdy", 0, 32'(iq_ready), 1);
    // Flush with 5 queued and a 6th offered in the same cycle.
    rob_full = 1;
    for (int k = 1; k <= 5; k++) begin
      instr_valid = 1; instr = addi(k + 10, k);
      next;
    end
    rob_full = 0; branch_mispredict = 1; instr = addi(20, 3);
    #1;
    chk("flush_noload", 0, 32'(rob_load), 0);
    chk("flush_nors", 0, 32'(rs_load), 0);
    next;
    branch_mispredict = 0; instr_valid = 0;
    #1;
    chk("flush_rdy", 0, 32'(iq_ready), 1);
    chk("flush_empty_load", 0, 32'(rob_load), 0);
    chk("flush_empty_rd", 0, 32'(rd), 0);
    next;
    chk("flush_not_stored", 0, 32'(rob_load), 0);
    // Reset mid-stream drops a stalled head.
    rob_full = 1;
    for (int k = 1; k <= 2; k++) begin
      instr_valid = 1; instr = addi(k, k);
      next;
    end
    instr_valid = 0; rst = 1;
    next;
    rst = 0; rob_full = 0;
    #1;
    chk("rst_noload", 0, 32'(rob_load), 0);
    chk("rst_rdy", 0, 32'(iq_ready), 1);
    chk("rst_type", 0, 32'(instr_type), 32'(OP_NONE));
    next;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
